// File: rtl/sd_clk_divider_pkg.sv
// Clock Control register constants and helpers shared by the SD clock divider
// and the clock-change / clock-supply sequencers.
package sd_clk_divider_pkg;

    localparam logic [11:0] CLK_CTRL_OFFSET = 12'h02C;

    localparam int ICE_BIT      = 0;
    localparam int ICS_BIT      = 1;
    localparam int SCE_BIT      = 2;
    localparam int FREQ_LO_LSB  = 6;
    localparam int FREQ_HI_LSB  = 8;
    localparam int SRST_ALL_BIT = 24;

    // 10-bit divisor: upper two bits live in [7:6], lower eight in [15:8]
    function automatic logic [9:0] freq_sel(input logic [31:0] wdata);
        return {wdata[FREQ_LO_LSB +: 2], wdata[FREQ_HI_LSB +: 8]};
    endfunction

    function automatic logic [15:0] pack_clk_ctrl(input logic [9:0] div,
                                                  input logic       sce,
                                                  input logic       ics,
                                                  input logic       ice);
        return {div[7:0], div[9:8], 3'b000, sce, ics, ice};
    endfunction

endpackage

// File: rtl/sd_clk_div_gen.sv
// SD clock generator: divides clk by 2*max(nact,1) with 50% duty, never
// truncates a high phase on a normal stop, and emits registered edge strobes.
module sd_clk_div_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       srst,
    input  logic       run,
    input  logic [9:0] nact,
    output logic       sd_clk_out,
    output logic       sd_clk_rise,
    output logic       sd_clk_fall
);

    logic [9:0] phase_r;
    logic [9:0] lim_s;
    logic       tc_s;

    // Half-period length and terminal-count detect
    always_comb begin
        if (nact == 10'd0) begin
            lim_s = 10'd1;
        end else begin
            lim_s = nact;
        end
        tc_s = (phase_r == (lim_s - 10'd1));
    end

    // Phase counter, output toggle and strobes; a high phase always completes
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r     <= 10'd0;
            sd_clk_out  <= 1'b0;
            sd_clk_rise <= 1'b0;
            sd_clk_fall <= 1'b0;
        end else if (srst) begin
            phase_r     <= 10'd0;
            sd_clk_out  <= 1'b0;
            sd_clk_rise <= 1'b0;
            sd_clk_fall <= sd_clk_out;
        end else if (run || sd_clk_out) begin
            if (tc_s) begin
                phase_r     <= 10'd0;
                sd_clk_out  <= ~sd_clk_out;
                sd_clk_rise <= ~sd_clk_out;
                sd_clk_fall <= sd_clk_out;
            end else begin
                phase_r     <= phase_r + 10'd1;
                sd_clk_rise <= 1'b0;
                sd_clk_fall <= 1'b0;
            end
        end else begin
            phase_r     <= 10'd0;
            sd_clk_rise <= 1'b0;
            sd_clk_fall <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_clk_divider.sv
// Clock Control register (enables, divisor, stable counter) plus the SD clock
// generator it drives.
module sd_clk_divider
    import sd_clk_divider_pkg::*;
#(
    parameter logic [11:0] REG_OFFSET    = CLK_CTRL_OFFSET,
    parameter int          STABLE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_reg_strb,
    input  logic [11:0] wr_reg_index,
    input  logic [31:0] wr_reg_output,
    output logic [15:0] clk_ctrl_rd,
    output logic        int_clk_stable,
    output logic        sd_clk_out,
    output logic        sd_clk_rise,
    output logic        sd_clk_fall
);

    localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);

    logic        accept_s;
    logic        srst_s;
    logic [9:0]  wr_div_s;
    logic        run_s;
    logic        gen_idle_s;
    logic [15:0] cnt_next_s;
    logic        unused_wr_bits_s;

    logic        ice_r;
    logic        sce_r;
    logic        stable_r;
    logic [9:0]  div_r;
    logic [9:0]  nact_r;
    logic [15:0] cnt_r;

    // Write decode and generator control
    always_comb begin
        accept_s   = wr_reg_strb && (wr_reg_index == REG_OFFSET);
        srst_s     = accept_s && wr_reg_output[SRST_ALL_BIT];
        wr_div_s   = freq_sel(wr_reg_output);
        run_s      = ice_r && stable_r && sce_r;
        gen_idle_s = !sd_clk_out && !run_s;
    end

    assign unused_wr_bits_s = ^{wr_reg_output[31:25], wr_reg_output[23:16],
                                wr_reg_output[5:3], wr_reg_output[ICS_BIT]};

    // Stable counter: restarts whenever the internal clock is off or retuned
    always_comb begin
        if (srst_s || !ice_r) begin
            cnt_next_s = 16'd0;
        end else if (accept_s && (wr_div_s != div_r)) begin
            cnt_next_s = 16'd0;
        end else if (cnt_r != STABLE_MAX) begin
            cnt_next_s = cnt_r + 16'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Register state; the active divisor only follows div_r while the generator is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            ice_r    <= 1'b0;
            sce_r    <= 1'b0;
            div_r    <= 10'd0;
            nact_r   <= 10'd0;
            cnt_r    <= 16'd0;
            stable_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            stable_r <= (cnt_next_s == STABLE_MAX);
            if (srst_s) begin
                ice_r  <= 1'b0;
                sce_r  <= 1'b0;
                div_r  <= 10'd0;
                nact_r <= 10'd0;
            end else begin
                if (accept_s) begin
                    ice_r <= wr_reg_output[ICE_BIT];
                    sce_r <= wr_reg_output[SCE_BIT];
                    div_r <= wr_div_s;
                end
                if (gen_idle_s) begin
                    nact_r <= div_r;
                end
            end
        end
    end

    assign clk_ctrl_rd    = pack_clk_ctrl(div_r, sce_r, stable_r, ice_r);
    assign int_clk_stable = stable_r;

    sd_clk_div_gen u_gen (
        .clk         (clk),
        .reset       (reset),
        .srst        (srst_s),
        .run         (run_s),
        .nact        (nact_r),
        .sd_clk_out  (sd_clk_out),
        .sd_clk_rise (sd_clk_rise),
        .sd_clk_fall (sd_clk_fall)
    );

endmodule

// File: tb/tb_sd_clk_divider.sv
// Randomised and directed bench for sd_clk_divider against a cycle-level
// behavioural model of the Clock Control register and SD clock.
module tb_sd_clk_divider;

    localparam int SC = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_reg_strb;
    logic [11:0] wr_reg_index;
    logic [31:0] wr_reg_output;
    logic [15:0] clk_ctrl_rd;
    logic        int_clk_stable;
    logic        sd_clk_out;
    logic        sd_clk_rise;
    logic        sd_clk_fall;

    always #5 clk = ~clk;

    sd_clk_divider #(.REG_OFFSET(12'h02C), .STABLE_CYCLES(SC)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_reg_strb    (wr_reg_strb),
        .wr_reg_index   (wr_reg_index),
        .wr_reg_output  (wr_reg_output),
        .clk_ctrl_rd    (clk_ctrl_rd),
        .int_clk_stable (int_clk_stable),
        .sd_clk_out     (sd_clk_out),
        .sd_clk_rise    (sd_clk_rise),
        .sd_clk_fall    (sd_clk_fall)
    );

    // Model state: register fields, stable count, and the clock as "age since run start"
    bit m_ice, m_sce, m_on, m_out, m_rise, m_fall;
    int m_n, m_cnt, m_nact, m_age;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [15:0] exp_rd();
        logic [9:0] nv;
        nv = 10'(m_n);
        return {nv[7:0], nv[9:8], 3'b000, m_sce, (m_cnt == SC), m_ice};
    endfunction

    task automatic model_step();
        bit acc, sw, run, nout;
        int lim, nn, base;
        acc = wr_reg_strb && (wr_reg_index == 12'h02C);
        sw  = acc && wr_reg_output[24];
        run = m_ice && (m_cnt == SC) && m_sce;
        lim = (m_nact == 0) ? 1 : m_nact;
        nn  = int'({wr_reg_output[7:6], wr_reg_output[15:8]});
        if (reset || sw) begin
            m_fall = sw && !reset && m_out;
            m_rise = 0; m_out = 0; m_on = 0; m_age = 0;
            m_ice = 0; m_sce = 0; m_n = 0; m_nact = 0; m_cnt = 0;
        end else begin
            if (run || m_out) begin
                base  = m_on ? m_age : 0;
                m_age = base + 1;
                nout  = ((m_age / lim) % 2) == 1;
                m_on  = run || nout;
            end else begin
                m_age = 0; m_on = 0; nout = 0;
            end
            m_rise = !m_out && nout;
            m_fall = m_out && !nout;
            if (!m_out && !run) m_nact = m_n;
            m_out = nout;
            if (!m_ice || (acc && nn != m_n)) m_cnt = 0;
            else if (m_cnt < SC) m_cnt = m_cnt + 1;
            if (acc) begin
                m_ice = wr_reg_output[0];
                m_sce = wr_reg_output[2];
                m_n   = nn;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [11:0] idx, input logic [31:0] d);
        reset = r; wr_reg_strb = s; wr_reg_index = idx; wr_reg_output = d;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    task automatic wr(input logic [31:0] d);
        step(1'b0, 1'b1, 12'h02C, d);
    endtask

    task automatic wait_stable(input string name, input int maxc);
        int n = 0;
        while (int_clk_stable !== 1'b1 && n < maxc) begin idle(1); n++; end
        chk(name, 32'(int_clk_stable), 32'd1);
    endtask

    task automatic wait_rise(input string name, input int maxc);
        int n = 0;
        while (sd_clk_rise !== 1'b1 && n < maxc) begin idle(1); n++; end
        chk(name, 32'(sd_clk_rise), 32'd1);
    endtask

    task automatic period(input string name, input int maxc, input int exp);
        int n = 0;
        do begin idle(1); n++; end while (sd_clk_rise !== 1'b1 && n < maxc);
        chk(name, 32'(n), 32'(exp));
    endtask

    // Every-cycle comparison of the DUT against the model, just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("rd", 32'(clk_ctrl_rd), 32'(exp_rd()));
            chk("stable", 32'(int_clk_stable), 32'(m_cnt == SC));
            chk("out", 32'(sd_clk_out), 32'(m_out));
            chk("rise", 32'(sd_clk_rise), 32'(m_rise));
            chk("fall", 32'(sd_clk_fall), 32'(m_fall));
            chk("rise_fall_excl", 32'(sd_clk_rise & sd_clk_fall), 32'd0);
        end
    end

    initial begin
        int e_out[7]  = '{0, 0, 1, 1, 0, 0, 1};
        int e_rise[7] = '{0, 0, 1, 0, 0, 0, 1};
        int e_fall[7] = '{0, 0, 0, 0, 1, 0, 0};
        int nedges;
        logic [31:0] d;
        logic [11:0] idx;

        repeat (3) step(1'b1, 1'b0, 12'h000, 32'h0);
        chk("rst_rd", 32'(clk_ctrl_rd), 32'h0);
        chk("rst_out", 32'(sd_clk_out), 32'h0);
        chk("rst_stable", 32'(int_clk_stable), 32'h0);

        // Stabilisation timing
        wr(32'h0000_0001);
        chk("ice_rd", 32'(clk_ctrl_rd), 32'h0001);
        idle(63);
        chk("stable_early", 32'(int_clk_stable), 32'h0);
        idle(1);
        chk("stable_t65", 32'(int_clk_stable), 32'h1);
        chk("rd_0003", 32'(clk_ctrl_rd), 32'h0003);
        chk("model_rd_0003", 32'(exp_rd()), 32'h0003);

        // Divide by 4: first rise two cycles after run, 2 high / 2 low
        wr(32'h0000_0205);
        wait_stable("div4_stable", 200);
        for (int i = 0; i < 7; i++) begin
            chk("div4_out", 32'(sd_clk_out), 32'(e_out[i]));
            chk("div4_rise", 32'(sd_clk_rise), 32'(e_rise[i]));
            chk("div4_fall", 32'(sd_clk_fall), 32'(e_fall[i]));
            idle(1);
        end

        // Divisor change while running: stable drops, new period after restart
        wr(32'h0000_0405);
        chk("retune_unstable", 32'(int_clk_stable), 32'h0);
        wait_stable("retune_stable", 200);
        wait_rise("retune_rise", 50);
        period("period_n4", 50, 8);

        // Glitch-free stop at N=8, disable one cycle after a rise
        wr(32'h0000_0805);
        wait_stable("n8_stable", 200);
        wait_rise("n8_rise", 50);
        idle(1);
        wr(32'h0000_0801);
        for (int i = 0; i < 6; i++) begin
            chk("stop_high", 32'(sd_clk_out), 32'h1);
            idle(1);
        end
        chk("stop_low", 32'(sd_clk_out), 32'h0);
        chk("stop_fall", 32'(sd_clk_fall), 32'h1);
        nedges = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (sd_clk_rise === 1'b1 || sd_clk_fall === 1'b1) nedges++;
        end
        chk("stop_no_edges", 32'(nedges), 32'h0);

        // Maximum divisor
        wr(32'h0000_FFC5);
        wait_stable("max_stable", 200);
        chk("max_rd", 32'(clk_ctrl_rd), 32'hFFC7);
        wait_rise("max_rise", 2500);
        period("period_max", 2100, 2046);

        // Software reset mid high phase, then foreign-index writes
        wr(32'h0100_0000);
        chk("srst_rd", 32'(clk_ctrl_rd), 32'h0);
        chk("srst_out", 32'(sd_clk_out), 32'h0);
        chk("srst_stable", 32'(int_clk_stable), 32'h0);
        step(1'b0, 1'b1, 12'h030, 32'hFFFF_FFFF);
        chk("other_idx_zero", 32'(clk_ctrl_rd), 32'h0);
        wr(32'h0000_0001);
        step(1'b0, 1'b1, 12'h030, 32'h0100_0005);
        chk("other_idx_keep", 32'(clk_ctrl_rd), 32'h0001);

        // Randomised traffic with small divisors so the clock actually runs
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                step(1'b1, 1'b0, 12'h000, 32'h0);
            end else if (r < 4) begin
                d = $urandom;
                if ($urandom_range(0, 7) != 0) begin
                    d[15:8] = 8'($urandom_range(0, 6));
                    d[7:6]  = 2'b00;
                end
                d[24] = ($urandom_range(0, 15) == 0);
                d[0]  = ($urandom_range(0, 3) != 0);
                d[2]  = ($urandom_range(0, 3) != 0);
                wr(d);
            end else if (r < 6) begin
                idx = 12'($urandom);
                if (idx == 12'h02C) idx = 12'h030;
                step(1'b0, 1'b1, idx, $urandom);
            end else begin
                idle(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
